// File: rtl/fx_pt_round_sat.sv
// fx_pt_round_sat
//   Output stage placed after the fixed-point adder. Takes the widened
//   (2*WIDTH+1)-bit sum, rescales it by SH = FRAC_IN-FRAC_OUT bits with
//   optional round-half-up, then saturates to WIDTH bits in the adder's
//   number format (0 unsigned, 1 two's complement, 2 sign-magnitude).
//   Two register stages with valid/ready flow control, plus a saturating
//   counter of overflowing output transfers.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   in_sum is valid
//   in_ready   stage can accept in_sum this cycle
//   in_sum     adder sum, 2*WIDTH+1 bits
//   out_valid  out_res is valid
//   out_ready  consumer accepts out_res
//   out_res    rounded, saturated result, WIDTH bits
//   out_ovf    out_res was clamped (qualified by out_valid)
//   clr_cnt    synchronous clear of ovf_cnt (wins over an increment)
//   ovf_cnt    number of overflowing output transfers, sticks at all-ones
module fx_pt_round_sat #(
  parameter int SGN      = 1,
  parameter int WIDTH    = 5,
  parameter int FRAC_IN  = 4,
  parameter int FRAC_OUT = 0,
  parameter int RND_MODE = 1,
  parameter int CNT_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2*WIDTH:0]   in_sum,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_res,
  output logic               out_ovf,
  input  logic               clr_cnt,
  output logic [CNT_W-1:0]   ovf_cnt
);

  localparam int IN_W = 2*WIDTH + 1;
  localparam int SH   = FRAC_IN - FRAC_OUT;
  // One extra bit so the rounding add can never wrap.
  localparam int RW   = IN_W + 1;

  localparam logic [RW-1:0] RND_ONE = RW'(1);
  localparam logic [RW-1:0] RND     = (RND_MODE == 1 && SH > 0) ?
                                      (RND_ONE << ((SH > 0) ? SH - 1 : 0)) : '0;
  localparam logic [RW-1:0] U_MAX   = RW'((1 << WIDTH) - 1);
  localparam logic [RW-1:0] S_MAX   = RW'((1 << (WIDTH - 1)) - 1);

  if (SGN < 0 || SGN > 2) begin : g_bad_sgn
    $error("fx_pt_round_sat: illegal SGN=%0d (legal: 0, 1, 2)", SGN);
  end
  if (FRAC_IN < FRAC_OUT) begin : g_bad_frac
    $error("fx_pt_round_sat: FRAC_IN (%0d) < FRAC_OUT (%0d)", FRAC_IN, FRAC_OUT);
  end

  // ---------------------------------------------------------------- state
  logic              s1_valid_q;
  logic [RW-1:0]     s1_r_q;
  logic              s1_sign_q;
  logic              out_valid_q;
  logic [WIDTH-1:0]  out_res_q;
  logic              out_ovf_q;
  logic [CNT_W-1:0]  ovf_cnt_q;

  // ------------------------------------------------------------ handshake
  logic s2_free, in_fire, s2_load, out_fire;

  // s2_free looks only at out_ready and state, so in_ready never depends
  // on in_valid.
  assign s2_free  = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_free;
  assign in_fire  = in_valid && in_ready;
  assign s2_load  = s1_valid_q && s2_free;
  assign out_fire = out_valid_q && out_ready;

  // -------------------------------------------------------- stage 1 comb
  logic [RW-1:0] ext_w, sum_w, s1_r_d;
  logic          s1_sign_d;

  always_comb begin
    ext_w     = '0;
    s1_sign_d = 1'b0;
    case (SGN)
      0:       ext_w = {1'b0, in_sum};
      1:       ext_w = {in_sum[IN_W-1], in_sum};
      default: begin
        // Sign-magnitude: round the magnitude alone, carry the sign aside.
        ext_w     = {2'b00, in_sum[IN_W-2:0]};
        s1_sign_d = in_sum[IN_W-1];
      end
    endcase
    sum_w = ext_w + RND;
    // Arithmetic shift for two's complement makes ties go toward +inf.
    if (SGN == 1) s1_r_d = $signed(sum_w) >>> SH;
    else          s1_r_d = sum_w >> SH;
  end

  // -------------------------------------------------------- stage 2 comb
  logic [WIDTH-1:0] out_res_d;
  logic             out_ovf_d;

  always_comb begin
    out_res_d = '0;
    out_ovf_d = 1'b0;
    case (SGN)
      0: begin
        if (s1_r_q > U_MAX) begin
          out_res_d = '1;
          out_ovf_d = 1'b1;
        end else begin
          out_res_d = s1_r_q[WIDTH-1:0];
        end
      end
      1: begin
        if ($signed(s1_r_q) > $signed(S_MAX)) begin
          out_res_d = {1'b0, {(WIDTH-1){1'b1}}};
          out_ovf_d = 1'b1;
        end else if ($signed(s1_r_q) < $signed(~S_MAX)) begin
          // ~S_MAX is -2^(WIDTH-1) at RW bits.
          out_res_d = {1'b1, {(WIDTH-1){1'b0}}};
          out_ovf_d = 1'b1;
        end else begin
          out_res_d = s1_r_q[WIDTH-1:0];
        end
      end
      default: begin
        if (s1_r_q > S_MAX) begin
          out_res_d = {s1_sign_q, {(WIDTH-1){1'b1}}};
          out_ovf_d = 1'b1;
        end else if (s1_r_q == '0) begin
          // A magnitude that rounded to zero is always emitted as +0.
          out_res_d = '0;
        end else begin
          out_res_d = {s1_sign_q, s1_r_q[WIDTH-2:0]};
        end
      end
    endcase
  end

  // ------------------------------------------------------------ registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_r_q      <= '0;
      s1_sign_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_res_q   <= '0;
      out_ovf_q   <= 1'b0;
      ovf_cnt_q   <= '0;
    end else begin
      // Stage 1 refills in the same cycle it hands its word to stage 2.
      if (in_fire) begin
        s1_valid_q <= 1'b1;
        s1_r_q     <= s1_r_d;
        s1_sign_q  <= s1_sign_d;
      end else if (s2_load) begin
        s1_valid_q <= 1'b0;
      end

      // Stage 2 only changes when it is empty or being drained, which
      // keeps out_res/out_ovf stable across a stall.
      if (s2_load) begin
        out_valid_q <= 1'b1;
        out_res_q   <= out_res_d;
        out_ovf_q   <= out_ovf_d;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end

      if (clr_cnt) begin
        ovf_cnt_q <= '0;
      end else if (out_fire && out_ovf_q && (ovf_cnt_q != '1)) begin
        ovf_cnt_q <= ovf_cnt_q + 1'b1;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_res   = out_res_q;
  assign out_ovf   = out_ovf_q;
  assign ovf_cnt   = ovf_cnt_q;

endmodule

// File: tb/tb_fx_pt_round_sat.sv
// Testbench for fx_pt_round_sat. Three instances cover the number formats:
//   index 0: SGN=0, RND_MODE=0   index 1: SGN=1, RND_MODE=1
//   index 2: SGN=2, RND_MODE=1   (all WIDTH=5, FRAC_IN=4, FRAC_OUT=0)
// Expected {ovf,res} values are queued when a word is accepted and are
// compared by a negedge monitor whenever the DUT presents an output.
module tb_fx_pt_round_sat;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        iv   [3];
  logic        ir   [3];
  logic [10:0] isum [3];
  logic        ov   [3];
  logic        ordy [3];
  logic [4:0]  ores [3];
  logic        oovf [3];
  logic        clr  [3];
  logic [7:0]  cnt  [3];

  fx_pt_round_sat #(.SGN(0), .WIDTH(5), .FRAC_IN(4), .FRAC_OUT(0), .RND_MODE(0), .CNT_W(8)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_sum(isum[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_res(ores[0]), .out_ovf(oovf[0]),
    .clr_cnt(clr[0]), .ovf_cnt(cnt[0]));
  fx_pt_round_sat #(.SGN(1), .WIDTH(5), .FRAC_IN(4), .FRAC_OUT(0), .RND_MODE(1), .CNT_W(8)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_sum(isum[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_res(ores[1]), .out_ovf(oovf[1]),
    .clr_cnt(clr[1]), .ovf_cnt(cnt[1]));
  fx_pt_round_sat #(.SGN(2), .WIDTH(5), .FRAC_IN(4), .FRAC_OUT(0), .RND_MODE(1), .CNT_W(8)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_sum(isum[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .out_res(ores[2]), .out_ovf(oovf[2]),
    .clr_cnt(clr[2]), .ovf_cnt(cnt[2]));

  int vectors = 0;
  int miscompares = 0;

  logic [5:0] q0 [$];
  logic [5:0] q1 [$];
  logic [5:0] q2 [$];

  // Reference: value/16 rounded half-up (or floored), then clamped.
  function automatic logic [5:0] model(int idx, logic [10:0] x);
    longint v;
    longint q;
    logic   s;
    logic   ovf;
    logic [4:0] r;
    s = 1'b0;
    ovf = 1'b0;
    if (idx == 0)      v = longint'(x);
    else if (idx == 1) v = longint'($signed(x));
    else begin
      v = longint'(x[9:0]);
      s = x[10];
    end
    if (idx != 0) v = v + 8;
    if (v >= 0) q = v / 16;
    else        q = -((-v + 15) / 16);
    if (idx == 0) begin
      if (q > 31) begin q = 31; ovf = 1'b1; end
    end else if (idx == 1) begin
      if (q > 15)       begin q = 15;  ovf = 1'b1; end
      else if (q < -16) begin q = -16; ovf = 1'b1; end
    end else begin
      if (q > 15) begin q = 15; ovf = 1'b1; end
      if (q == 0) s = 1'b0;
    end
    if (idx == 2) r = {s, q[3:0]};
    else          r = q[4:0];
    return {ovf, r};
  endfunction

  function automatic int qsize(int idx);
    if (idx == 0) return q0.size();
    if (idx == 1) return q1.size();
    return q2.size();
  endfunction

  function automatic logic [5:0] qfront(int idx);
    if (idx == 0) return q0[0];
    if (idx == 1) return q1[0];
    return q2[0];
  endfunction

  task automatic qpush(int idx, logic [5:0] e);
    if (idx == 0)      q0.push_back(e);
    else if (idx == 1) q1.push_back(e);
    else               q2.push_back(e);
  endtask

  task automatic qpop(int idx);
    if (idx == 0)      void'(q0.pop_front());
    else if (idx == 1) void'(q1.pop_front());
    else               void'(q2.pop_front());
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: sampled mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 3; i++) begin
        if (ov[i]) begin
          if (qsize(i) == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL unexpected_out%0d observed=%0h expected=none", i, {oovf[i], ores[i]});
          end else begin
            check($sformatf("out%0d%s", i, ordy[i] ? "" : "_stalled"),
                  {26'd0, oovf[i], ores[i]}, {26'd0, qfront(i)});
            if (ordy[i]) begin
              $display("out%0d res=%b ovf=%b", i, ores[i], oovf[i]);
              qpop(i);
            end
          end
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(int idx, logic [10:0] x, logic [5:0] e);
    bit acc;
    acc = 1'b0;
    iv[idx] = 1'b1;
    isum[idx] = x;
    for (int c = 0; c < 40 && !acc; c++) begin
      @(negedge clk);
      if (ir[idx]) begin
        acc = 1'b1;
        qpush(idx, e);
        $display("in%0d sum=%h exp=%b", idx, x, e);
      end
      @(posedge clk);
      #1;
    end
    iv[idx] = 1'b0;
    if (!acc) begin
      vectors++;
      miscompares++;
      $error("FAIL send_timeout%0d observed=not_accepted expected=accepted", idx);
    end
  endtask

  task automatic drain(int idx);
    for (int c = 0; c < 60 && qsize(idx) > 0; c++) begin
      @(posedge clk);
      #1;
    end
    check($sformatf("drain%0d_pending", idx), 32'(qsize(idx)), 32'd0);
  endtask

  logic [10:0] bp_w [5];
  logic [10:0] rx;

  initial begin
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0; isum[i] = '0; ordy[i] = 1'b1; clr[i] = 1'b0;
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_out_valid%0d", i), 32'(ov[i]), 32'd0);
      check($sformatf("rst_out_res%0d", i), 32'(ores[i]), 32'd0);
      check($sformatf("rst_out_ovf%0d", i), 32'(oovf[i]), 32'd0);
      check($sformatf("rst_ovf_cnt%0d", i), 32'(cnt[i]), 32'd0);
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("in_ready_idle", 32'(ir[1]), 32'd1);

    // Two's complement, round-half-up.
    send(1, 11'h058, 6'b0_00110);
    send(1, 11'h7A8, 6'b0_11011);
    send(1, 11'h12C, 6'b1_01111);
    drain(1);
    check("cnt1_after_directed", 32'(cnt[1]), 32'd1);

    // Sign-magnitude, round-half-up.
    send(2, {1'b1, 10'd88},   6'b0_10110);
    send(2, {1'b1, 10'd4},    6'b0_00000);
    send(2, {1'b0, 10'd8},    6'b0_00001);
    send(2, {1'b1, 10'd1023}, 6'b1_11111);
    drain(2);
    check("cnt2_after_directed", 32'(cnt[2]), 32'd1);

    // Unsigned, truncate.
    send(0, 11'h7FF, 6'b1_11111);
    send(0, 11'h05F, 6'b0_00101);
    drain(0);
    check("cnt0_after_directed", 32'(cnt[0]), 32'd1);

    // Random words streamed back to back through each instance.
    for (int n = 0; n < 20; n++) begin
      for (int i = 0; i < 3; i++) begin
        rx = 11'($urandom);
        send(i, rx, model(i, rx));
      end
    end
    for (int i = 0; i < 3; i++) drain(i);

    // Backpressure: consumer stalls, two words fill the pipe.
    bp_w[0] = 11'h010; bp_w[1] = 11'h7C8; bp_w[2] = 11'h0F7;
    bp_w[3] = 11'h300; bp_w[4] = 11'h41F;
    ordy[1] = 1'b0;
    send(1, bp_w[0], model(1, bp_w[0]));
    send(1, bp_w[1], model(1, bp_w[1]));
    iv[1] = 1'b1;
    isum[1] = bp_w[2];
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_in_ready_full", 32'(ir[1]), 32'd0);
      @(posedge clk);
      #1;
    end
    ordy[1] = 1'b1;
    send(1, bp_w[2], model(1, bp_w[2]));
    send(1, bp_w[3], model(1, bp_w[3]));
    send(1, bp_w[4], model(1, bp_w[4]));
    drain(1);

    // Counter saturation.
    for (int n = 0; n < 300; n++) send(1, 11'h3F0, model(1, 11'h3F0));
    drain(1);
    check("cnt1_saturated", 32'(cnt[1]), 32'd255);
    clr[1] = 1'b1;
    @(posedge clk);
    #1;
    clr[1] = 1'b0;
    check("cnt1_cleared_idle", 32'(cnt[1]), 32'd0);
    send(1, 11'h3F0, model(1, 11'h3F0));
    drain(1);
    check("cnt1_one", 32'(cnt[1]), 32'd1);

    // Clear in the same cycle as an overflowing transfer; also latency.
    send(1, 11'h3F0, model(1, 11'h3F0));
    check("latency_cycle1", 32'(ov[1]), 32'd0);
    @(posedge clk);
    #1;
    check("latency_cycle2", 32'(ov[1]), 32'd1);
    clr[1] = 1'b1;
    @(posedge clk);
    #1;
    clr[1] = 1'b0;
    check("cnt1_clr_priority", 32'(cnt[1]), 32'd0);
    drain(1);

    // Asynchronous reset with two words in flight.
    send(1, 11'h3F0, model(1, 11'h3F0));
    drain(1);
    check("cnt1_before_rst", 32'(cnt[1]), 32'd1);
    ordy[1] = 1'b0;
    send(1, 11'h058, model(1, 11'h058));
    send(1, 11'h12C, model(1, 11'h12C));
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_out_valid", 32'(ov[1]), 32'd0);
    check("rst_async_ovf_cnt", 32'(cnt[1]), 32'd0);
    check("rst_async_out_res", 32'(ores[1]), 32'd0);
    q0.delete(); q1.delete(); q2.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ordy[1] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("no_stale_after_rst", 32'(ov[1]), 32'd0);
    send(1, 11'h058, 6'b0_00110);
    check("post_rst_latency1", 32'(ov[1]), 32'd0);
    @(posedge clk);
    #1;
    check("post_rst_latency2", 32'(ov[1]), 32'd1);
    drain(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
